// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: UART receiver handshake, consumer pop port and status.
// The slave side is the buffer; the master side is whoever drives the
// receiver outputs and the pop/clear controls.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_data;
  logic                rx_avail;
  logic                rx_error;
  logic                rx_ack;
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overrun;
  logic                frame_err;
  logic [7:0]          drop_count;
  logic [7:0]          err_count;
  logic                rx_idle;
  logic                clr_flags;

  modport slave (
    input  rx_data, rx_avail, rx_error, rd_en, clr_flags,
    output rx_ack, rd_data, rd_valid, empty, full, level,
           overrun, frame_err, drop_count, err_count, rx_idle
  );

  modport master (
    output rx_data, rx_avail, rx_error, rd_en, clr_flags,
    input  rx_ack, rd_data, rd_valid, empty, full, level,
           overrun, frame_err, drop_count, err_count, rx_idle
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: acknowledges receiver events, stores good bytes in a
// circular FIFO, tracks framing errors / overruns and flags an idle timeout.
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] TIMEOUT    = 16'd40000
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [15:0]           tmo_cnt;
  logic [15:0]           tmo_nxt;
  logic                  ack_q;
  logic                  rd_valid_q;
  logic [7:0]            rd_data_q;
  logic                  overrun_q;
  logic                  frame_err_q;
  logic [7:0]            drop_cnt_q;
  logic [7:0]            err_cnt_q;
  logic                  idle_q;

  logic evt;
  logic byte_evt;
  logic err_evt;
  logic empty_w;
  logic full_w;
  logic pop;
  logic push;
  logic drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Event decode, push/pop arbitration, next level and timeout count
  always_comb begin
    evt       = (bus.rx_avail | bus.rx_error) & ~ack_q;
    byte_evt  = evt & bus.rx_avail;
    err_evt   = evt & bus.rx_error;
    empty_w   = (level_q == '0);
    full_w    = (level_q == LVL_FULL);
    pop       = bus.rd_en & ~empty_w;
    // A full FIFO still takes the byte when a pop frees a slot this cycle.
    push      = byte_evt & (~full_w | pop);
    drop      = byte_evt & ~push;
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
    tmo_nxt = tmo_cnt;
    if (push || empty_w)
      tmo_nxt = '0;
    else if (tmo_cnt != TIMEOUT)
      tmo_nxt = tmo_cnt + 16'd1;
  end

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.rx_data;
  end

  // Handshake, pointers, level and pop output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ack_q      <= evt;
      level_q    <= level_nxt;
      rd_valid_q <= pop;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky error flags and saturating counters; clear beats a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else if (bus.clr_flags) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (drop) begin
        overrun_q  <= 1'b1;
        drop_cnt_q <= sat_inc8(drop_cnt_q);
      end
      if (err_evt) begin
        frame_err_q <= 1'b1;
        err_cnt_q   <= sat_inc8(err_cnt_q);
      end
    end
  end

  // Idle timeout: counter plus flag raised only on the cycle the limit is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      idle_q  <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      if (bus.clr_flags || push || (level_nxt == '0))
        idle_q <= 1'b0;
      else if ((tmo_nxt == TIMEOUT) && (tmo_cnt != TIMEOUT))
        idle_q <= 1'b1;
    end
  end

  assign bus.rx_ack     = ack_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.level      = level_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.drop_count = drop_cnt_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.rx_idle    = idle_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: receiver model, scoreboard of expected pop data,
// one task per scenario.
module tb_uart_rx_fifo;

  localparam int DL2 = 4;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT(16'd20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;
  int ack_cnt;
  int dbl_ack;
  int rdv_cnt;
  int mlevel;
  logic prev_ack;
  logic [7:0] exp_q[$];

  // Count acks and back-to-back acks
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_ack) ack_cnt++;
      if (bus.rx_ack && prev_ack) dbl_ack++;
    end
    prev_ack = bus.rx_ack;
  end

  // Scoreboard: every rd_valid must deliver the oldest expected byte
  always @(negedge clk) begin
    if (!reset && bus.rd_valid) begin
      logic [7:0] e;
      rdv_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got rd_data=%02h, required no rd_valid", bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== e)
          $display("FAIL pop_data: got %02h, required %02h", bus.rd_data, e);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: hold the event until rx_ack is seen
  task automatic send(input logic [7:0] b, input logic av, input logic er);
    bit got;
    got = 0;
    bus.rx_data  = b;
    bus.rx_avail = av;
    bus.rx_error = er;
    if (av) begin
      if (mlevel < (1 << DL2)) begin
        exp_q.push_back(b);
        mlevel++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rx_ack) begin
        got = 1;
        break;
      end
    end
    bus.rx_avail = 1'b0;
    bus.rx_error = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL ack_timeout: got rx_ack=0 after 10 cycles, required 1");
    end
  endtask

  task automatic pop_n(input int n);
    bus.rd_en = 1'b1;
    repeat (n) tick();
    bus.rd_en = 1'b0;
    mlevel -= n;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.empty, bus.full, bus.level, bus.rx_ack, bus.rd_valid} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0})
      $display("FAIL reset_status: got empty=%b full=%b level=%0d ack=%b rdv=%b, required 1 0 0 0 0",
               bus.empty, bus.full, bus.level, bus.rx_ack, bus.rd_valid);
    else passed++;
    total++;
    if ({bus.overrun, bus.frame_err, bus.drop_count, bus.err_count, bus.rx_idle, bus.rd_data} !== 29'd0)
      $display("FAIL reset_flags: got ovr=%b fe=%b dc=%0d ec=%0d idle=%b rd=%02h, required all 0",
               bus.overrun, bus.frame_err, bus.drop_count, bus.err_count, bus.rx_idle, bus.rd_data);
    else passed++;
  endtask

  task automatic test_single_byte();
    int a0;
    int r0;
    a0 = ack_cnt;
    r0 = rdv_cnt;
    send(8'hA5, 1'b1, 1'b0);
    repeat (3) tick();
    total++;
    if ((ack_cnt - a0) !== 1) $display("FAIL single_acks: got %0d, required 1", ack_cnt - a0);
    else passed++;
    total++;
    if (bus.level !== 5'd1) $display("FAIL single_level: got %0d, required 1", bus.level);
    else passed++;
    pop_n(1);
    total++;
    if (bus.rd_data !== 8'hA5 || bus.rd_valid !== 1'b1)
      $display("FAIL single_pop: got rd=%02h rdv=%b, required a5 1", bus.rd_data, bus.rd_valid);
    else passed++;
    tick();
    total++;
    if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || (rdv_cnt - r0) !== 1)
      $display("FAIL single_after: got empty=%b rdv=%b pulses=%0d, required 1 0 1",
               bus.empty, bus.rd_valid, rdv_cnt - r0);
    else passed++;
  endtask

  task automatic test_fill_overrun();
    int a0;
    a0 = ack_cnt;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
    tick();
    total++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overrun !== 1'b0)
      $display("FAIL fill_full: got full=%b level=%0d ovr=%b, required 1 16 0",
               bus.full, bus.level, bus.overrun);
    else passed++;
    send(8'h10, 1'b1, 1'b0);
    tick();
    total++;
    if (bus.overrun !== 1'b1 || bus.drop_count !== 8'd1 || bus.level !== 5'd16 || (ack_cnt - a0) !== 17)
      $display("FAIL fill_overrun: got ovr=%b dc=%0d level=%0d acks=%0d, required 1 1 16 17",
               bus.overrun, bus.drop_count, bus.level, ack_cnt - a0);
    else passed++;
    pop_n(16);
    tick();
    total++;
    if (bus.empty !== 1'b1 || exp_q.size() !== 0)
      $display("FAIL fill_drain: got empty=%b pending=%0d, required 1 0", bus.empty, exp_q.size());
    else passed++;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h0F)
      $display("FAIL pop_empty: got rdv=%b rd=%02h, required 0 0f", bus.rd_valid, bus.rd_data);
    else passed++;
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b1, 1'b0);
    tick();
    bus.rx_data  = 8'h30;
    bus.rx_avail = 1'b1;
    bus.rd_en    = 1'b1;
    exp_q.push_back(8'h30);
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.rx_ack !== 1'b1) $display("FAIL fpp_ack: got %b, required 1", bus.rx_ack);
    else passed++;
    bus.rx_avail = 1'b0;
    total++;
    if (bus.level !== 5'd16 || bus.overrun !== 1'b0 || bus.rd_data !== 8'h20)
      $display("FAIL fpp_state: got level=%0d ovr=%b rd=%02h, required 16 0 20",
               bus.level, bus.overrun, bus.rd_data);
    else passed++;
    pop_n(16);
    tick();
    total++;
    if (bus.empty !== 1'b1 || exp_q.size() !== 0)
      $display("FAIL fpp_drain: got empty=%b pending=%0d, required 1 0", bus.empty, exp_q.size());
    else passed++;
  endtask

  task automatic test_frame_err();
    int a0;
    a0 = ack_cnt;
    repeat (3) send(8'h00, 1'b0, 1'b1);
    tick();
    total++;
    if ((ack_cnt - a0) !== 3 || bus.frame_err !== 1'b1 || bus.err_count !== 8'd3 || bus.level !== 5'd0)
      $display("FAIL ferr_count: got acks=%0d fe=%b ec=%0d level=%0d, required 3 1 3 0",
               ack_cnt - a0, bus.frame_err, bus.err_count, bus.level);
    else passed++;
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    total++;
    if ({bus.overrun, bus.frame_err, bus.drop_count, bus.err_count, bus.rx_idle} !== 19'd0)
      $display("FAIL ferr_clear: got fe=%b ec=%0d ovr=%b dc=%0d idle=%b, required all 0",
               bus.frame_err, bus.err_count, bus.overrun, bus.drop_count, bus.rx_idle);
    else passed++;
    // Clear in the same cycle as an error event wins over the set
    bus.rx_error  = 1'b1;
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    bus.rx_error  = 1'b0;
    total++;
    if (bus.rx_ack !== 1'b1 || bus.frame_err !== 1'b0 || bus.err_count !== 8'd0)
      $display("FAIL clr_priority: got ack=%b fe=%b ec=%0d, required 1 0 0",
               bus.rx_ack, bus.frame_err, bus.err_count);
    else passed++;
  endtask

  task automatic test_timeout();
    send(8'h5A, 1'b1, 1'b0);
    repeat (19) tick();
    total++;
    if (bus.rx_idle !== 1'b0) $display("FAIL idle_early: got %b, required 0", bus.rx_idle);
    else passed++;
    tick();
    total++;
    if (bus.rx_idle !== 1'b1) $display("FAIL idle_set: got %b, required 1", bus.rx_idle);
    else passed++;
    send(8'h5B, 1'b1, 1'b0);
    total++;
    if (bus.rx_idle !== 1'b0) $display("FAIL idle_push_clear: got %b, required 0", bus.rx_idle);
    else passed++;
    repeat (20) tick();
    total++;
    if (bus.rx_idle !== 1'b1) $display("FAIL idle_reset: got %b, required 1", bus.rx_idle);
    else passed++;
    pop_n(2);
    repeat (30) tick();
    total++;
    if (bus.rx_idle !== 1'b0 || bus.empty !== 1'b1)
      $display("FAIL idle_drain: got idle=%b empty=%b, required 0 1", bus.rx_idle, bus.empty);
    else passed++;
  endtask

  task automatic test_wrap_reset();
    int sent;
    sent = 0;
    for (int it = 0; it < 400 && (sent < 40 || mlevel > 0); it++) begin
      if (sent < 40 && mlevel < 16 && ($urandom_range(0, 1) == 1 || mlevel == 0)) begin
        send(8'($urandom), 1'b1, 1'b0);
        sent++;
      end else if (mlevel > 0) begin
        pop_n(1);
      end
    end
    tick();
    total++;
    if (bus.empty !== 1'b1 || exp_q.size() !== 0 || sent !== 40)
      $display("FAIL wrap_order: got empty=%b pending=%0d sent=%0d, required 1 0 40",
               bus.empty, exp_q.size(), sent);
    else passed++;
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    bus.rx_data  = 8'h77;
    bus.rx_avail = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rx_ack, bus.level, bus.empty, bus.full, bus.rd_valid} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL midreset_status: got ack=%b level=%0d empty=%b full=%b rdv=%b, required 0 0 1 0 0",
               bus.rx_ack, bus.level, bus.empty, bus.full, bus.rd_valid);
    else passed++;
    total++;
    if ({bus.frame_err, bus.err_count, bus.overrun, bus.drop_count, bus.rx_idle} !== 19'd0)
      $display("FAIL midreset_flags: got fe=%b ec=%0d ovr=%b dc=%0d idle=%b, required all 0",
               bus.frame_err, bus.err_count, bus.overrun, bus.drop_count, bus.rx_idle);
    else passed++;
    exp_q.delete();
    mlevel = 0;
    tick();
    reset = 1'b0;
    send(8'h77, 1'b1, 1'b0);
    tick();
    total++;
    if (bus.level !== 5'd1) $display("FAIL post_reset_capture: got level=%0d, required 1", bus.level);
    else passed++;
    pop_n(1);
    tick();
    total++;
    if (exp_q.size() !== 0 || bus.empty !== 1'b1)
      $display("FAIL post_reset_pop: got pending=%0d empty=%b, required 0 1", exp_q.size(), bus.empty);
    else passed++;
  endtask

  initial begin
    total = 0; passed = 0; ack_cnt = 0; dbl_ack = 0; rdv_cnt = 0; mlevel = 0;
    prev_ack = 1'b0;
    bus.rx_data = 8'h00; bus.rx_avail = 1'b0; bus.rx_error = 1'b0;
    bus.rd_en = 1'b0; bus.clr_flags = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single_byte();
    test_fill_overrun();
    test_full_push_pop();
    test_frame_err();
    test_timeout();
    test_wrap_reset();
    total++;
    if (dbl_ack !== 0) $display("FAIL ack_back_to_back: got %0d double acks, required 0", dbl_ack);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
